dds_phase_meas: RTL and testbench

- Measures the phase increment of an incoming phase-accumulator stream. This is the receive-side counterpart to the DDS phase accumulator.
- Each valid phase sample is differenced modulo 2^PHASE_ACC_WIDTH against the previous sample.
- Differences are summed over 2^LOG2_AVG samples. The block then reports the average increment and the number of accumulator wraps in that window.
- Used for loopback checking of DDS tuning and for frequency estimation of a recovered phase stream.

---
 rtl/dds_phase_meas.sv | 134 +++++++++++++
 tb/tb_dds_phase_meas.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_meas.sv
// Receive-side phase increment meter: differences a phase-accumulator stream
// and reports the average increment and the wrap count per 2^LOG2_AVG differences.
module dds_phase_meas #(
  parameter int PHASE_ACC_WIDTH = 16,
  parameter int PHASE_INC_WIDTH = 16,
  parameter int LOG2_AVG        = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       enable_i,
  input  logic [PHASE_ACC_WIDTH-1:0] phase_i,
  input  logic                       phase_valid_i,
  output logic [PHASE_INC_WIDTH-1:0] phase_inc_o,
  output logic                       phase_inc_valid_o,
  output logic [LOG2_AVG:0]          wrap_count_o,
  output logic                       busy_o
);

  localparam int PAW = PHASE_ACC_WIDTH;
  localparam int PIW = PHASE_INC_WIDTH;
  localparam int SW  = PAW + LOG2_AVG;
  localparam int CW  = LOG2_AVG + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << LOG2_AVG) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    ACCUM = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [PAW-1:0] prev_q, prev_d;
  logic [SW-1:0]  sum_q, sum_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  wraps_q, wraps_d;
  logic [PIW-1:0] inc_q, inc_d;
  logic           inc_valid_q, inc_valid_d;
  logic [CW-1:0]  wrap_out_q, wrap_out_d;

  logic [PAW-1:0] diff;
  logic           is_wrap;
  logic [SW-1:0]  total;
  logic [CW-1:0]  wraps_tot;
  logic [PAW-1:0] avg;
  logic [PIW-1:0] avg_out;

  // Unsigned wrapped subtraction gives the true increment across accumulator rollover.
  assign diff      = phase_i - prev_q;
  assign is_wrap   = (phase_i < prev_q);
  assign total     = sum_q + SW'(diff);
  assign wraps_tot = wraps_q + CW'(is_wrap);
  assign avg       = PAW'(total >> LOG2_AVG);

  if (PIW >= PAW) begin : g_ext
    assign avg_out = PIW'(avg);
  end else begin : g_sat
    assign avg_out = (|avg[PAW-1:PIW]) ? '1 : avg[PIW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    sum_d       = sum_q;
    count_d     = count_q;
    wraps_d     = wraps_q;
    inc_d       = inc_q;
    wrap_out_d  = wrap_out_q;
    inc_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) state_d = PRIME;
      end
      PRIME: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (phase_valid_i) begin
          prev_d  = phase_i;
          sum_d   = '0;
          count_d = '0;
          wraps_d = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (phase_valid_i) begin
          prev_d = phase_i;
          if (count_q == LAST) begin
            // Window closes; prev is kept so the next window needs no re-prime.
            inc_d       = avg_out;
            wrap_out_d  = wraps_tot;
            inc_valid_d = 1'b1;
            sum_d       = '0;
            count_d     = '0;
            wraps_d     = '0;
          end else begin
            sum_d   = total;
            count_d = count_q + 1'b1;
            wraps_d = wraps_tot;
          end
        end
        if (!enable_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      sum_q       <= '0;
      count_q     <= '0;
      wraps_q     <= '0;
      inc_q       <= '0;
      inc_valid_q <= 1'b0;
      wrap_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      wraps_q     <= wraps_d;
      inc_q       <= inc_d;
      inc_valid_q <= inc_valid_d;
      wrap_out_q  <= wrap_out_d;
    end
  end

  assign phase_inc_o       = inc_q;
  assign phase_inc_valid_o = inc_valid_q;
  assign wrap_count_o      = wrap_out_q;
  assign busy_o            = (state_q != IDLE);

endmodule

// File: tb/tb_dds_phase_meas.sv
// Directed plus randomized bench for dds_phase_meas against a window-level
// reference model (sample queue, plain arithmetic average and wrap tally).
module tb_dds_phase_meas;

  localparam int PAW = 16;
  localparam int PIW = 16;
  localparam int L   = 4;
  localparam int N   = 1 << L;

  logic           clk;
  logic           rst_n;
  logic           enable;
  logic [PAW-1:0] phase;
  logic           phase_valid;
  logic [PIW-1:0] phase_inc;
  logic           phase_inc_valid;
  logic [L:0]     wrap_count;
  logic           busy;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit             m_busy;
  bit             m_have_prev;
  logic [PAW-1:0] m_prev;
  logic [PAW-1:0] win_q[$];
  int             m_wraps;
  logic [PIW-1:0] exp_inc;
  logic [L:0]     exp_wrap;
  logic           exp_valid;
  int             obs_pulses;

  dds_phase_meas #(
    .PHASE_ACC_WIDTH(PAW),
    .PHASE_INC_WIDTH(PIW),
    .LOG2_AVG(L)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .enable_i(enable),
    .phase_i(phase),
    .phase_valid_i(phase_valid),
    .phase_inc_o(phase_inc),
    .phase_inc_valid_o(phase_inc_valid),
    .wrap_count_o(wrap_count),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_busy      = 1'b0;
    m_have_prev = 1'b0;
    win_q.delete();
    m_wraps     = 0;
    exp_inc     = '0;
    exp_wrap    = '0;
    exp_valid   = 1'b0;
  endtask

  // One clock: drive at negedge, check registered outputs just after posedge.
  task automatic step(input bit en, input bit v, input logic [PAW-1:0] ph);
    longint s;
    longint a;
    @(negedge clk);
    enable      = en;
    phase_valid = v;
    phase       = ph;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    if (m_busy && v) begin
      if (!m_have_prev) begin
        m_prev      = ph;
        m_have_prev = 1'b1;
        win_q.delete();
        m_wraps     = 0;
      end else begin
        win_q.push_back(ph - m_prev);
        if (ph < m_prev) m_wraps++;
        m_prev = ph;
        if (win_q.size() == N) begin
          s = 0;
          foreach (win_q[i]) s += longint'(win_q[i]);
          a = s / N;
          if (a >= (longint'(1) << PIW)) a = (longint'(1) << PIW) - 1;
          exp_inc   = PIW'(a);
          exp_wrap  = (L+1)'(m_wraps);
          exp_valid = 1'b1;
          win_q.delete();
          m_wraps   = 0;
        end
      end
    end
    if (!en) begin
      m_have_prev = 1'b0;
      win_q.delete();
      m_wraps = 0;
    end
    m_busy = en;
    if (phase_inc_valid === 1'b1) obs_pulses++;
    chk("valid", 32'(phase_inc_valid), 32'(exp_valid));
    chk("inc",   32'(phase_inc),       32'(exp_inc));
    chk("wraps", 32'(wrap_count),      32'(exp_wrap));
    chk("busy",  32'(busy),            32'(m_busy));
  endtask

  // Leave IDLE and enter PRIME with one empty enabled cycle.
  task automatic go_idle_then_prime();
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
  endtask

  task automatic ramp(input logic [PAW-1:0] start, input logic [PAW-1:0] inc, input int n, input bit gaps);
    logic [PAW-1:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, p);
      if (gaps) step(1'b1, 1'b0, ~p);
      p = p + inc;
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_inc",   32'(phase_inc),       32'h0);
    chk("rst_valid", 32'(phase_inc_valid), 32'h0);
    chk("rst_wraps", 32'(wrap_count),      32'h0);
    chk("rst_busy",  32'(busy),            32'h0);
    @(negedge clk);
    enable      = 1'b0;
    phase_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [PAW-1:0] p;
    rst_n       = 1'b0;
    enable      = 1'b0;
    phase_valid = 1'b0;
    phase       = '0;
    obs_pulses  = 0;
    model_clear();
    #1;
    chk("init_inc",   32'(phase_inc),       32'h0);
    chk("init_valid", 32'(phase_inc_valid), 32'h0);
    chk("init_wraps", 32'(wrap_count),      32'h0);
    chk("init_busy",  32'(busy),            32'h0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // constant increment, no wraps
    go_idle_then_prime();
    ramp(16'h0000, 16'h0100, 17, 1'b0);
    chk("const_inc",  32'(phase_inc),  32'h0100);
    chk("const_wrap", 32'(wrap_count), 32'd0);

    // one accumulator wrap on the last sample
    go_idle_then_prime();
    ramp(16'h0000, 16'h1000, 17, 1'b0);
    chk("wrap_inc",  32'(phase_inc),  32'h1000);
    chk("wrap_wrap", 32'(wrap_count), 32'd1);

    // large increment, wraps on all steps but the first
    go_idle_then_prime();
    ramp(16'h0000, 16'hF000, 17, 1'b0);
    chk("large_inc",  32'(phase_inc),  32'hF000);
    chk("large_wrap", 32'(wrap_count), 32'd15);

    // gapped samples across two continuous windows
    go_idle_then_prime();
    obs_pulses = 0;
    ramp(16'h0000, 16'h0003, 33, 1'b1);
    chk("gap_pulses", 32'(obs_pulses), 32'd2);
    chk("gap_inc",    32'(phase_inc),  32'h0003);

    // alternating 0x10/0x11 diffs: sum 0x108 truncates to 0x10
    go_idle_then_prime();
    p = 16'h0040;
    step(1'b1, 1'b1, p);
    for (int i = 0; i < N; i++) begin
      p = p + ((i % 2 == 0) ? 16'h0010 : 16'h0011);
      step(1'b1, 1'b1, p);
    end
    chk("trunc_inc", 32'(phase_inc), 32'h0010);

    // abort by disable after 8 samples: no pulse, outputs hold
    go_idle_then_prime();
    obs_pulses = 0;
    ramp(16'h0500, 16'h0020, 8, 1'b0);
    step(1'b0, 1'b0, '0);
    chk("abort_busy",   32'(busy),       32'd0);
    chk("abort_hold",   32'(phase_inc),  32'h0010);
    chk("abort_pulses", 32'(obs_pulses), 32'd0);

    // samples while IDLE are ignored
    step(1'b0, 1'b1, 16'h1111);
    step(1'b0, 1'b1, 16'h2222);

    // reset in the middle of a window
    go_idle_then_prime();
    ramp(16'h0000, 16'h0040, 6, 1'b0);
    async_reset();

    // restart: first sample only primes
    go_idle_then_prime();
    ramp(16'h1234, 16'h0200, 17, 1'b0);
    chk("restart_inc", 32'(phase_inc), 32'h0200);

    // completion coinciding with disable still reports
    go_idle_then_prime();
    ramp(16'h0000, 16'h0007, 16, 1'b0);
    step(1'b0, 1'b1, 16'h0070);
    chk("late_dis_inc", 32'(phase_inc), 32'h0007);

    // randomized traffic with occasional disables
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), 16'($urandom));
    end
    // randomized steady increments with jitter
    for (int k = 0; k < 6; k++) begin
      logic [PAW-1:0] inc;
      inc = 16'($urandom);
      go_idle_then_prime();
      p = 16'($urandom);
      for (int i = 0; i < 40; i++) begin
        step(1'b1, ($urandom_range(0, 2) != 0), p);
        p = p + inc + 16'($urandom_range(0, 15));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
